// File: rtl/weight_pingpong_manager.sv
// Double-buffered weight store: beat stream fills the shadow half while the active half is read; WEIGHT_MGR_PARITY_EN adds per-slice parity.
// Reads return RD_LATENCY cycles after rd_en_i, one per cycle; wr_ready_o stays low from end-of-layer until the consumer swaps.
module weight_pingpong_manager #(
  parameter int NUM_BANKS  = 8,
  parameter int SLICES     = 8,
  parameter int SLICE_W    = 72,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_valid_i,
  output logic                                  wr_ready_o,
  input  logic [SLICE_W-1:0]                    wr_data_i,
  input  logic                                  wr_last_i,
  input  logic                                  wr_addr_rst_i,
  output logic                                  wr_overflow_o,
  input  logic                                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr_i,
  input  logic                                  rd_swap_i,
  output logic [NUM_BANKS*SLICES*SLICE_W-1:0]   data_out_o,
  output logic                                  data_valid_o,
  output logic                                  active_buf_o,
  output logic                                  shadow_full_o,
  output logic                                  swap_done_o
`ifdef WEIGHT_MGR_PARITY_EN
  ,
  output logic                                  parity_err_o
`endif
);
  localparam int LANES  = NUM_BANKS * SLICES;
  localparam int CAP    = DEPTH * LANES;
  localparam int CNT_W  = $clog2(CAP + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW     = LANES * SLICE_W;
  localparam int P      = RD_LATENCY - 1;
`ifdef WEIGHT_MGR_PARITY_EN
  localparam int MW     = SLICE_W + 1;
`else
  localparam int MW     = SLICE_W;
`endif
  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  typedef enum logic {ST_LOAD = 1'b0, ST_HOLD = 1'b1} wr_state_e;

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  active_q, active_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  overflow_q, overflow_d;
  logic                  swap_done_q;
  logic                  wr_acc, wr_full, wr_we, swap;
  logic [LANE_W-1:0]     wr_lane;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [MW-1:0]         wr_mem_dat;
  logic [MW-1:0]         mem_q [2][LANES][DEPTH];

  logic                  req_vld_q, req_half_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [P-1:0]          vld_pipe_q;
  logic [DW-1:0]         dat_pipe_q [P];
  logic                  data_valid_q;
  logic [DW-1:0]         data_out_q;

  assign wr_acc  = wr_valid_i & wr_ready_o;
  assign wr_full = (wr_cnt_q == CAP_C);
  assign wr_we   = wr_acc & ~wr_full & ~rst_i;
  assign swap    = rd_swap_i & shadow_full_q;
  // Beat order walks slices first, then banks, then word address.
  assign wr_lane = LANE_W'(wr_cnt_q % LANES_C);
  assign wr_word = ADDR_WIDTH'(wr_cnt_q / LANES_C);
`ifdef WEIGHT_MGR_PARITY_EN
  assign wr_mem_dat = {^wr_data_i, wr_data_i};
`else
  assign wr_mem_dat = wr_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (wr_acc && wr_last_i) state_d = ST_HOLD;
      ST_HOLD: if (swap)                state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    wr_ready_o = (state_q == ST_LOAD);
  end

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    shadow_full_d = shadow_full_q;
    overflow_d    = overflow_q | (wr_acc & wr_full);
    active_d      = active_q ^ swap;
    if (state_q == ST_LOAD) begin
      if (wr_addr_rst_i)               wr_cnt_d = '0;
      else if (wr_acc && wr_last_i)    wr_cnt_d = '0;
      else if (wr_acc && !wr_full)     wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (wr_acc && wr_last_i) shadow_full_d = 1'b1;
    if (swap)                shadow_full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q      <= '0;
      active_q      <= 1'b0;
      shadow_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      overflow_q    <= overflow_d;
      swap_done_q   <= swap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_we) mem_q[~active_q][wr_lane][wr_word] <= wr_mem_dat;
  end

  // The half is captured at issue so reads in flight across a swap stay on the old half.
  always_ff @(posedge clk_i) begin
    req_addr_q <= rd_addr_i;
    req_half_q <= active_q;
    for (int l = 0; l < LANES; l++)
      dat_pipe_q[0][l*SLICE_W +: SLICE_W] <= mem_q[req_half_q][l][req_addr_q][SLICE_W-1:0];
    for (int i = 1; i < P; i++)
      dat_pipe_q[i] <= dat_pipe_q[i-1];
  end

`ifdef WEIGHT_MGR_PARITY_EN
  logic         rd_perr;
  logic [P-1:0] perr_pipe_q;
  logic         parity_err_q;

  always_comb begin
    rd_perr = 1'b0;
    for (int l = 0; l < LANES; l++)
      rd_perr = rd_perr | (^mem_q[req_half_q][l][req_addr_q]);
  end

  always_ff @(posedge clk_i) begin
    perr_pipe_q[0] <= rd_perr;
    for (int i = 1; i < P; i++)
      perr_pipe_q[i] <= perr_pipe_q[i-1];
    if (rst_i) parity_err_q <= 1'b0;
    else       parity_err_q <= vld_pipe_q[P-1] & perr_pipe_q[P-1];
  end

  assign parity_err_o = parity_err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_vld_q    <= 1'b0;
      vld_pipe_q   <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      req_vld_q     <= rd_en_i;
      vld_pipe_q[0] <= req_vld_q;
      for (int i = 1; i < P; i++)
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      data_valid_q <= vld_pipe_q[P-1];
      if (vld_pipe_q[P-1]) data_out_q <= dat_pipe_q[P-1];
    end
  end

  assign wr_overflow_o = overflow_q;
  assign data_out_o    = data_out_q;
  assign data_valid_o  = data_valid_q;
  assign active_buf_o  = active_q;
  assign shadow_full_o = shadow_full_q;
  assign swap_done_o   = swap_done_q;

endmodule

// File: tb/tb_weight_pingpong_manager.sv
// Bench for weight_pingpong_manager: a layer-level model predicts control state each cycle and queues expected
// read responses; an independent monitor pops and compares whenever data_valid is presented.
module tb_weight_pingpong_manager;
  localparam int NB = 2, S = 2, SW = 72, DEPTH = 2, L = 3, AW = 1;
  localparam int LANES = NB * S, CAP = DEPTH * LANES, DW = LANES * SW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, wr_valid_i, wr_last_i, wr_addr_rst_i, rd_en_i, rd_swap_i;
  logic [SW-1:0] wr_data_i;
  logic [AW-1:0] rd_addr_i;
  logic          wr_ready_o, wr_overflow_o, data_valid_o, active_buf_o, shadow_full_o, swap_done_o;
  logic [DW-1:0] data_out_o;
`ifdef WEIGHT_MGR_PARITY_EN
  logic          parity_err_o;
`endif

  weight_pingpong_manager #(
    .NUM_BANKS(NB), .SLICES(S), .SLICE_W(SW), .DEPTH(DEPTH), .RD_LATENCY(L), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .wr_last_i(wr_last_i), .wr_addr_rst_i(wr_addr_rst_i), .wr_overflow_o(wr_overflow_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_swap_i(rd_swap_i),
    .data_out_o(data_out_o), .data_valid_o(data_valid_o), .active_buf_o(active_buf_o),
    .shadow_full_o(shadow_full_o), .swap_done_o(swap_done_o)
`ifdef WEIGHT_MGR_PARITY_EN
    , .parity_err_o(parity_err_o)
`endif
  );

  typedef struct {
    logic [DW-1:0] dat;
    bit            known;
    bit            perr;
    int            due;
  } rd_exp_t;

  // Reference model: the two halves as plain arrays plus the layer-level bookkeeping.
  logic [SW-1:0] m_mem     [2][LANES][DEPTH];
  bit            m_known   [2][LANES][DEPTH];
  bit            m_corrupt [2][LANES][DEPTH];
  bit            m_active, m_sf, m_hold, m_ovf, m_swapd, m_rst_edge;
  int            m_cnt;
  int            cyc;
  rd_exp_t       sbq[$];
  logic [DW-1:0] m_last;
  bit            m_last_known;
  int            n_chk, n_pass;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    chk(nm, {{(DW-1){1'b0}}, act}, {{(DW-1){1'b0}}, exp});
  endtask

  task automatic model_edge();
    bit acc, sw, full;
    rd_exp_t e;
    cyc++;
    m_rst_edge = rst_i;
    if (rst_i) begin
      m_active = 0; m_sf = 0; m_hold = 0; m_ovf = 0; m_swapd = 0; m_cnt = 0;
      sbq.delete();
    end else begin
      acc  = wr_valid_i && !m_hold;
      sw   = rd_swap_i && m_sf;
      full = (m_cnt == CAP);
      if (acc && !full) begin
        m_mem[m_active ^ 1'b1][m_cnt % LANES][m_cnt / LANES]   = wr_data_i;
        m_known[m_active ^ 1'b1][m_cnt % LANES][m_cnt / LANES] = 1'b1;
      end
      if (acc && full) m_ovf = 1;
      if (!m_hold) begin
        if (wr_addr_rst_i)          m_cnt = 0;
        else if (acc && wr_last_i)  m_cnt = 0;
        else if (acc && !full)      m_cnt++;
      end
      if (rd_en_i) begin
        e.known = 1; e.perr = 0; e.due = cyc + L;
        for (int l = 0; l < LANES; l++) begin
          e.dat[l*SW +: SW] = m_mem[m_active][l][rd_addr_i];
          e.known = e.known && m_known[m_active][l][rd_addr_i];
          e.perr  = e.perr || m_corrupt[m_active][l][rd_addr_i];
        end
        sbq.push_back(e);
      end
      if (acc && wr_last_i) begin m_sf = 1; m_hold = 1; end
      m_swapd = sw;
      if (sw) begin m_active = !m_active; m_sf = 0; m_hold = 0; end
    end
  endtask

  always @(posedge clk) model_edge();

  task automatic mon_edge();
    rd_exp_t e;
    bit exp_v;
    if (m_rst_edge) begin m_last = '0; m_last_known = 1'b1; end
    chk1("wr_ready", wr_ready_o, !m_hold);
    chk1("active_buf", active_buf_o, m_active);
    chk1("shadow_full", shadow_full_o, m_sf);
    chk1("swap_done", swap_done_o, m_swapd);
    chk1("wr_overflow", wr_overflow_o, m_ovf);
    exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
    chk1("data_valid", data_valid_o, exp_v);
    if (data_valid_o === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.known) chk("data_out", data_out_o, e.dat);
`ifdef WEIGHT_MGR_PARITY_EN
      if (e.known) chk1("parity_err", parity_err_o, e.perr);
`endif
      m_last = e.dat; m_last_known = e.known;
    end else begin
      if (m_last_known) chk("data_hold", data_out_o, m_last);
`ifdef WEIGHT_MGR_PARITY_EN
      chk1("parity_idle", parity_err_o, 1'b0);
`endif
    end
  endtask

  always @(negedge clk) mon_edge();

  task automatic drive(bit r, bit v, logic [SW-1:0] d, bit last, bit arst, bit ren, logic [AW-1:0] a, bit sw);
    rst_i = r; wr_valid_i = v; wr_data_i = d; wr_last_i = last; wr_addr_rst_i = arst;
    rd_en_i = ren; rd_addr_i = a; rd_swap_i = sw;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  function automatic logic [SW-1:0] rnd_beat();
    logic [95:0] r96;
    r96 = {$urandom(), $urandom(), $urandom()};
    return r96[SW-1:0];
  endfunction

  initial begin
    rst_i = 1; wr_valid_i = 0; wr_data_i = '0; wr_last_i = 0; wr_addr_rst_i = 0;
    rd_en_i = 0; rd_addr_i = '0; rd_swap_i = 0;
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    chk1("rst_wr_ready", wr_ready_o, 1'b1);
    chk1("rst_active_buf", active_buf_o, 1'b0);
    chk1("rst_data_valid", data_valid_o, 1'b0);
    chk("rst_data_out", data_out_o, '0);

    // Layer of beats k = k, then swap and read addr 0/1: bank b slice s at addr 0 holds b*S+s.
    for (int k = 0; k < CAP; k++) drive(0, 1, SW'(k), k == CAP - 1, 0, 0, '0, 0);
    chk1("load_shadow_full", shadow_full_o, 1'b1);
    chk1("load_wr_ready", wr_ready_o, 1'b0);
    idle(2);
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    chk1("swap_active_buf", active_buf_o, 1'b1);
    drive(0, 0, '0, 0, 0, 1, AW'(0), 0);
    drive(0, 0, '0, 0, 0, 1, AW'(1), 0);
    idle(L + 2);

    // Load all-ones into the other half while reading the active one every cycle.
    for (int i = 0; i < CAP; i++) drive(0, 1, '1, i == CAP - 1, 0, 1, AW'(i), 0);
    idle(1);
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    drive(0, 0, '0, 0, 0, 1, AW'(0), 0);
    idle(L + 2);

    // Swap requests with nothing loaded, and on the wr_last beat itself, are both ignored.
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    for (int i = 0; i < CAP; i++) drive(0, 1, rnd_beat(), i == CAP - 1, 0, 0, '0, i == CAP - 1);
    idle(2);
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    idle(L + 2);

    // Overflow: beats beyond capacity are dropped; wr_last still completes the load.
    for (int i = 0; i < CAP + 2; i++) drive(0, 1, rnd_beat(), i == CAP + 1, 0, 0, '0, 0);
    idle(1);
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    drive(0, 0, '0, 0, 0, 1, AW'(1), 0);
    idle(L + 2);

    // Reads issued right before and on the swap edge, then reset mid-load and mid-read.
    for (int i = 0; i < CAP; i++) drive(0, 1, rnd_beat(), i == CAP - 1, i == 2, 0, '0, 0);
    drive(0, 0, '0, 0, 0, 1, AW'(0), 0);
    drive(0, 0, '0, 0, 0, 1, AW'(1), 1);
    drive(0, 0, '0, 0, 0, 1, AW'(0), 0);
    idle(L + 1);
    for (int i = 0; i < 3; i++) drive(0, 1, rnd_beat(), 0, 0, 1, AW'(i), 0);
    drive(1, 1, rnd_beat(), 0, 0, 1, AW'(0), 0);
    chk1("midrst_wr_ready", wr_ready_o, 1'b1);
    chk1("midrst_active_buf", active_buf_o, 1'b0);
    idle(L + 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(299) == 0, $urandom_range(3) != 0, rnd_beat(), $urandom_range(11) == 0,
            $urandom_range(39) == 0, $urandom_range(1) == 1, AW'($urandom()), $urandom_range(5) == 0);

`ifdef WEIGHT_MGR_PARITY_EN
    drive(1, 0, '0, 0, 0, 0, '0, 0);
    for (int i = 0; i < CAP; i++) drive(0, 1, rnd_beat(), i == CAP - 1, 0, 0, '0, 0);
    drive(0, 0, '0, 0, 0, 0, '0, 1);
    idle(1);
    dut.mem_q[m_active][2][0][SW] = ~dut.mem_q[m_active][2][0][SW];
    m_corrupt[m_active][2][0] = 1'b1;
    drive(0, 0, '0, 0, 0, 1, AW'(0), 0);
    drive(0, 0, '0, 0, 0, 1, AW'(1), 0);
`endif

    idle(L + 3);
    chk("sb_drain", DW'(sbq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/weight_pingpong_manager.md
Name: weight_pingpong_manager

Overview:
- Parametrised successor to the 8x8 URAM weight store. Adds a configurable bank count, slice count, slice width and read latency.
- Adds double-buffering: the CPU loads layer N+1 into the shadow half while the conv controller reads layer N from the active half.
- Write side is a valid/ready stream with an end-of-layer marker. Read side is address-driven with fixed latency.
- Sits between the host DMA stream and the conv_pe weight inputs.

Parameters:
- NUM_BANKS, 8, number of output banks (one per PE column).
- SLICES, 8, slices per bank; each slice is one write beat wide.
- SLICE_W, 72, bits per write beat / per slice.
- DEPTH, 4096, words per bank per half-buffer.
- RD_LATENCY, 3, rd_en to data_valid in cycles; must be at least 2.
- ADDR_WIDTH, $clog2(DEPTH), read address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- wr_data  in  SLICE_W  write beat.
- wr_last  in  1  final beat of a layer load.
- wr_addr_rst  in  1  clears the shadow write counter.
- wr_overflow  out  1  sticky; a beat was dropped past capacity.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  word address in the active half.
- rd_swap  in  1  pulse: consumer finished layer, request buffer swap.
- data_out  out  NUM_BANKS*SLICES*SLICE_W  bank b, slice s at bits [(b*SLICES+s)*SLICE_W +: SLICE_W].
- data_valid  out  1  data_out valid.
- active_buf  out  1  half currently being read.
- shadow_full  out  1  shadow half is loaded and awaiting swap.
- swap_done  out  1  one-cycle pulse when a swap is taken.

Behaviour:
- Storage: 2 halves x NUM_BANKS x SLICES memories, each DEPTH x SLICE_W. Physical half select = buffer bit. Contents are not reset.
- Write counter wr_cnt maps each beat as follows:
  - slice = wr_cnt mod SLICES
  - bank = (wr_cnt / SLICES) mod NUM_BANKS
  - addr = wr_cnt / (SLICES*NUM_BANKS)
- Beats always go to half ~active_buf.
- Writer FSM:
  - LOAD: wr_ready=1. Each accepted beat writes one slice and increments wr_cnt. An accepted beat with wr_last sets shadow_full=1, clears wr_cnt and goes to HOLD.
  - HOLD: wr_ready=0. Exits to LOAD on the swap cycle.
- Capacity: when wr_cnt == DEPTH*NUM_BANKS*SLICES, accepted beats are dropped (no write, no increment) and wr_overflow sets. A wr_last beat in this state still completes the load. wr_overflow clears only on rst.
- wr_addr_rst: clears wr_cnt in LOAD. In HOLD it is ignored. It has priority over a same-cycle accepted beat; that beat is written at the old address, then the count is 0.
- Swap: rd_swap && shadow_full (registered value) gives, next edge:
  - active_buf toggles, shadow_full=0, swap_done=1 for one cycle, FSM goes to LOAD.
  - rd_swap with shadow_full=0 is ignored; no error is flagged.
  - rd_swap in the same cycle as the wr_last beat does not swap; a swap needs a later pulse.
- Read: rd_en at cycle T samples rd_addr and active_buf. data_out and data_valid are updated at edge T+RD_LATENCY. Fully pipelined, one read per cycle.
  - Reads in flight across a swap complete from the half captured at issue.
  - data_out holds its last value when data_valid=0.
- Reset (rst=1 at an edge):
  - wr_cnt=0, FSM=LOAD, wr_ready=1 after reset, active_buf=0, shadow_full=0, swap_done=0, wr_overflow=0.
  - Valid pipeline cleared, data_valid=0, data_out=0.
  - In-flight reads are discarded. A reset mid-load abandons the partial load.

Optional Feature:
- Macro WEIGHT_MGR_PARITY_EN.
- When defined:
  - Each stored slice carries an extra even-parity bit computed at write.
  - On read, parity is rechecked per slice.
  - Output port parity_err (1 bit) is aligned with data_valid and is high if any slice mismatches.
  - Reset value of parity_err is 0.
- When undefined: there are no parity bits and no parity_err port, and the timing is identical.

Test Plan:
- Defaults, rst, stream 64 beats (beat k = 72'hk) with wr_last on beat 63 -> shadow_full=1, wr_ready=0. Pulse rd_swap -> swap_done pulse, active_buf=1. rd_en addr 0 -> 3 cycles later data_valid=1 and bank b slice s = b*8+s.
- Read half 1 continuously while loading half 0 with all-ones -> reads unaffected. After swap, addr 0 returns all-ones in every slice.
- rd_swap issued without a load, and in the same cycle as wr_last -> no toggle, no swap_done. A later rd_swap -> swaps.
- DEPTH=2, NUM_BANKS=2, SLICES=2: 8 beats fill the half. The 9th accepted beat sets wr_overflow with no write. wr_last on the 10th beat -> shadow_full=1.
- rd_en issued the cycle before a swap -> data_out comes from the old half. rst asserted mid-load and mid-read -> data_valid stays 0, active_buf=0, wr_ready=1 next cycle.
- WEIGHT_MGR_PARITY_EN: force a stored bit flip via hierarchical deposit -> parity_err=1 with data_valid. Clean data -> parity_err=0.
